// File: rtl/cabac_ctx_ram_ctrl.sv
// CABAC context save/restore controller: streams WORD_NUM 16-bit context words
// into a single-port SRAM (save) or out of it onto a valid-only stream (load).
module cabac_ctx_ram_ctrl #(
  parameter int WORD_NUM = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        save_start_i,
  input  logic        load_start_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic        ctx_in_valid_i,
  output logic        ctx_in_ready_o,
  input  logic [15:0] ctx_in_data_i,
  output logic        ctx_out_valid_o,
  output logic [5:0]  ctx_out_addr_o,
  output logic [15:0] ctx_out_data_o,
  output logic        ram_cen_o,
  output logic        ram_wen_o,
  output logic [5:0]  ram_addr_o,
  output logic [15:0] ram_data_o,
  input  logic [15:0] ram_data_i
);

  localparam logic [5:0] LAST_IDX = 6'(WORD_NUM - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SAVE  = 3'd1,
    LOAD  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic        wr_hs_p0;
  logic        rd_en_p0;
  logic        vld_p1;
  logic [5:0]  rd_addr_p1;

  assign wr_hs_p0 = (state == SAVE) && ctx_in_valid_i;
  assign rd_en_p0 = (state == LOAD);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        // save wins when both starts arrive together
        if (save_start_i) begin
          state_nxt = SAVE;
          cnt_nxt   = '0;
        end else if (load_start_i) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      SAVE: begin
        if (wr_hs_p0) begin
          cnt_nxt = cnt + 6'd1;
          if (cnt == LAST_IDX) state_nxt = DONE;
        end
      end
      LOAD: begin
        cnt_nxt = cnt + 6'd1;
        if (cnt == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      vld_p1 <= rd_en_p0;
    end
  end

  // p0 -> p1: read address follows the SRAM's one-cycle read latency
  always_ff @(posedge clk) begin
    if (rd_en_p0) rd_addr_p1 <= cnt;
  end

  always_comb begin
    busy_o         = (state != IDLE);
    done_o         = (state == DONE);
    ctx_in_ready_o = (state == SAVE);
  end

  always_comb begin
    ram_cen_o  = ~(wr_hs_p0 | rd_en_p0);
    ram_wen_o  = ~wr_hs_p0;
    ram_addr_o = (wr_hs_p0 | rd_en_p0) ? cnt : 6'd0;
    ram_data_o = wr_hs_p0 ? ctx_in_data_i : 16'd0;
  end

  always_comb begin
    ctx_out_valid_o = vld_p1;
    ctx_out_addr_o  = vld_p1 ? rd_addr_p1 : 6'd0;
    ctx_out_data_o  = vld_p1 ? ram_data_i : 16'd0;
  end

endmodule
